// File: rtl/alu_result_stage_pkg.sv
// Shared ALU select codes and the HI/LO commit state type.
// Also used by the ALU that produces reg_C.
package alu_result_stage_pkg;

  localparam int DATA_W = 32;

  localparam logic [4:0] OP_MUL  = 5'b00010;
  localparam logic [4:0] OP_DIV  = 5'b00011;
  localparam logic [4:0] OP_BRZR = 5'b10101;
  localparam logic [4:0] OP_BRNZ = 5'b10110;
  localparam logic [4:0] OP_BRMI = 5'b10111;
  localparam logic [4:0] OP_BRPL = 5'b11000;
  localparam logic [4:0] OP_MFHI = 5'b11011;
  localparam logic [4:0] OP_MFLO = 5'b11100;

  typedef enum logic {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } hilo_state_t;

  function automatic logic is_muldiv(
    input logic [4:0] code
  );
    return (code == OP_MUL) ||
           (code == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Control/data bundle between the datapath sequencer and alu_result_stage.
// Flag outputs exist only when ALU_RESULT_FLAGS_EN is defined.
interface alu_result_stage_if #(
  parameter int DATA_W = 32
);
  logic [4:0]          Control;
  logic [2*DATA_W-1:0] alu_C;
  logic                Z_in;
  logic                Zlow_out;
  logic                Zhigh_out;
  logic                LO_out;
  logic                HI_out;
  logic                con_in;
  logic [DATA_W-1:0]   con_val;
  logic [DATA_W-1:0]   bus_out;
  logic                bus_drive;
  logic                CON;
  logic                hilo_busy;
  logic                z_valid;
`ifdef ALU_RESULT_FLAGS_EN
  logic                flag_z;
  logic                flag_n;
`endif

  modport master (
    output Control, alu_C, Z_in,
    output Zlow_out, Zhigh_out,
    output LO_out, HI_out,
    output con_in, con_val,
    input  bus_out, bus_drive,
    input  CON, hilo_busy, z_valid
`ifdef ALU_RESULT_FLAGS_EN
    , input flag_z, flag_n
`endif
  );

  modport slave (
    input  Control, alu_C, Z_in,
    input  Zlow_out, Zhigh_out,
    input  LO_out, HI_out,
    input  con_in, con_val,
    output bus_out, bus_drive,
    output CON, hilo_busy, z_valid
`ifdef ALU_RESULT_FLAGS_EN
    , output flag_z, flag_n
`endif
  );

endinterface

// File: rtl/alu_result_stage_con_ff_logic.sv
// Branch condition decode and the CON flip-flop.
module con_ff_logic #(
  parameter int DATA_W = 32
) (
  input  logic              Clock,
  input  logic              Clear,
  input  logic [4:0]        Control,
  input  logic              con_in,
  input  logic [DATA_W-1:0] con_val,
  output logic              CON
);
  import alu_result_stage_pkg::*;

  logic taken;
  logic con_q;

  always_comb begin
    taken = 1'b0;
    unique case (Control)
      OP_BRZR: taken = (con_val == '0);
      OP_BRNZ: taken = (con_val != '0);
      OP_BRMI: taken = con_val[DATA_W-1];
      OP_BRPL: taken = ~con_val[DATA_W-1];
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      con_q <= 1'b0;
    end else if (con_in) begin
      con_q <= taken;
    end
  end

  assign CON = con_q;

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: Z register, HI/LO commit FSM, mfhi/mflo bypass, CON.
// Define ALU_RESULT_FLAGS_EN to add registered flag_z/flag_n outputs.
module alu_result_stage #(
  parameter int DATA_W = 32
) (
  input  logic            Clock,
  input  logic            Clear,
  alu_result_stage_if.slave bus
);
  import alu_result_stage_pkg::*;

  localparam int ZW = 2 * DATA_W;

  hilo_state_t       state;
  hilo_state_t       state_next;
  logic [ZW-1:0]     z;
  logic [ZW-1:0]     z_next;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic [DATA_W-1:0] hi_src;
  logic [DATA_W-1:0] lo_src;
  logic              z_valid_q;
  logic              muldiv;
  logic              commit;
  logic              con;

  assign muldiv = is_muldiv(bus.Control);

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = IDLE;
    commit     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.Z_in && muldiv) state_next = COMMIT;
      end
      COMMIT: begin
        commit = 1'b1;
        if (bus.Z_in && muldiv) state_next = COMMIT;
      end
      default: state_next = IDLE;
    endcase
  end

  // Z still holds the result being committed, so forward it.
  always_comb begin
    hi_src = hi;
    lo_src = lo;
    if (commit) begin
      hi_src = z[ZW-1:DATA_W];
      lo_src = z[DATA_W-1:0];
    end
  end

  always_comb begin
    z_next = bus.alu_C;
    unique case (bus.Control)
      OP_MFHI: z_next = {{DATA_W{1'b0}}, hi_src};
      OP_MFLO: z_next = {{DATA_W{1'b0}}, lo_src};
      default: z_next = bus.alu_C;
    endcase
  end

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      z         <= '0;
      z_valid_q <= 1'b0;
    end else if (bus.Z_in) begin
      z         <= z_next;
      z_valid_q <= 1'b1;
    end
  end

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      hi <= '0;
      lo <= '0;
    end else if (commit) begin
      hi <= z[ZW-1:DATA_W];
      lo <= z[DATA_W-1:0];
    end
  end

`ifdef ALU_RESULT_FLAGS_EN
  logic flag_z_q;
  logic flag_n_q;

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else if (bus.Z_in) begin
      if (muldiv) begin
        flag_z_q <= (z_next == '0);
        flag_n_q <= z_next[ZW-1];
      end else begin
        flag_z_q <= (z_next[DATA_W-1:0] == '0);
        flag_n_q <= z_next[DATA_W-1];
      end
    end
  end

  assign bus.flag_z = flag_z_q;
  assign bus.flag_n = flag_n_q;
`endif

  always_comb begin
    bus.bus_out   = '0;
    bus.bus_drive = bus.Zlow_out | bus.Zhigh_out |
                    bus.LO_out | bus.HI_out;
    if (bus.Zlow_out) begin
      bus.bus_out = z[DATA_W-1:0];
    end else if (bus.Zhigh_out) begin
      bus.bus_out = z[ZW-1:DATA_W];
    end else if (bus.LO_out) begin
      bus.bus_out = lo;
    end else if (bus.HI_out) begin
      bus.bus_out = hi;
    end
  end

  con_ff_logic #(
    .DATA_W (DATA_W)
  ) u_con (
    .Clock   (Clock),
    .Clear   (Clear),
    .Control (bus.Control),
    .con_in  (bus.con_in),
    .con_val (bus.con_val),
    .CON     (con)
  );

  assign bus.CON       = con;
  assign bus.hilo_busy = (state == COMMIT);
  assign bus.z_valid   = z_valid_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage with hand-computed expectations.
module tb_alu_result_stage;

  localparam logic [4:0] C_ADD  = 5'b00100;
  localparam logic [4:0] C_MUL  = 5'b00010;
  localparam logic [4:0] C_DIV  = 5'b00011;
  localparam logic [4:0] C_BRZR = 5'b10101;
  localparam logic [4:0] C_BRNZ = 5'b10110;
  localparam logic [4:0] C_BRMI = 5'b10111;
  localparam logic [4:0] C_BRPL = 5'b11000;
  localparam logic [4:0] C_MFHI = 5'b11011;
  localparam logic [4:0] C_MFLO = 5'b11100;

  logic Clock;
  logic Clear;
  int   n_cmp;
  int   n_bad;

  alu_result_stage_if #(.DATA_W(32)) bus ();

  alu_result_stage #(
    .DATA_W (32)
  ) dut (
    .Clock (Clock),
    .Clear (Clear),
    .bus   (bus)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic check(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // strobe order: {Zlow, Zhigh, LO, HI}
  task automatic rd(
    input string       tag,
    input logic [3:0]  stb,
    input logic [31:0] exp
  );
    {bus.Zlow_out, bus.Zhigh_out, bus.LO_out, bus.HI_out} = stb;
    #1;
    check(tag, {32'b0, bus.bus_out}, {32'b0, exp});
    check({tag, "_drv"}, {63'b0, bus.bus_drive}, {63'b0, |stb});
    {bus.Zlow_out, bus.Zhigh_out, bus.LO_out, bus.HI_out} = 4'b0;
  endtask

  task automatic con_step(
    input string       tag,
    input logic [4:0]  ctl,
    input logic [31:0] val,
    input logic        exp
  );
    bus.Control = ctl;
    bus.con_val = val;
    bus.con_in  = 1'b1;
    tick();
    bus.con_in  = 1'b0;
    check(tag, {63'b0, bus.CON}, {63'b0, exp});
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    Clear = 1'b1;
    bus.Control   = C_ADD;
    bus.alu_C     = '0;
    bus.Z_in      = 1'b0;
    bus.Zlow_out  = 1'b0;
    bus.Zhigh_out = 1'b0;
    bus.LO_out    = 1'b0;
    bus.HI_out    = 1'b0;
    bus.con_in    = 1'b0;
    bus.con_val   = '0;
    tick();
    tick();

    // reset state
    check("rst_busy", {63'b0, bus.hilo_busy}, 64'd0);
    check("rst_zv", {63'b0, bus.z_valid}, 64'd0);
    check("rst_con", {63'b0, bus.CON}, 64'd0);
    rd("rst_idle", 4'b0000, 32'h0);
    rd("rst_zlow", 4'b1000, 32'h0);
    rd("rst_hi", 4'b0001, 32'h0);
    Clear = 1'b0;
    tick();

    // plain Z capture
    bus.Control = C_ADD;
    bus.alu_C   = 64'h0000_0000_0000_0005;
    bus.Z_in    = 1'b1;
    tick();
    bus.Z_in    = 1'b0;
    check("add_zv", {63'b0, bus.z_valid}, 64'd1);
    check("add_busy", {63'b0, bus.hilo_busy}, 64'd0);
    rd("add_zlow", 4'b1000, 32'h5);
    rd("add_zhigh", 4'b0100, 32'h0);
`ifdef ALU_RESULT_FLAGS_EN
    check("add_fz", {63'b0, bus.flag_z}, 64'd0);
    check("add_fn", {63'b0, bus.flag_n}, 64'd0);
`endif

    // mul commit
    bus.Control = C_MUL;
    bus.alu_C   = 64'h0000_0001_FFFF_FFFE;
    bus.Z_in    = 1'b1;
    tick();
    bus.Z_in    = 1'b0;
    bus.Control = C_ADD;
    check("mul_busy1", {63'b0, bus.hilo_busy}, 64'd1);
    tick();
    check("mul_busy0", {63'b0, bus.hilo_busy}, 64'd0);
    rd("mul_hi", 4'b0001, 32'h1);
    rd("mul_lo", 4'b0010, 32'hFFFF_FFFE);
    rd("prio_zh_lo", 4'b0110, 32'h1);
    rd("prio_zl_zh", 4'b1100, 32'hFFFF_FFFE);
    rd("prio_lo_hi", 4'b0011, 32'hFFFF_FFFE);

    // mfhi in COMMIT cycle sees bypassed value
    bus.Control = C_MUL;
    bus.alu_C   = 64'h0000_0001_FFFF_FFFE;
    bus.Z_in    = 1'b1;
    tick();
    bus.Control = C_MFHI;
    bus.alu_C   = 64'hDEAD_BEEF_CAFE_F00D;
    tick();
    bus.Z_in    = 1'b0;
    bus.Control = C_ADD;
    rd("mfhi_zlow", 4'b1000, 32'h1);
    rd("mfhi_zhigh", 4'b0100, 32'h0);
    check("mfhi_busy", {63'b0, bus.hilo_busy}, 64'd0);

    // mflo bypass with a fresh product
    bus.Control = C_MUL;
    bus.alu_C   = 64'h0000_0002_0000_0003;
    bus.Z_in    = 1'b1;
    tick();
    bus.Control = C_MFLO;
    bus.alu_C   = 64'h1111_1111_2222_2222;
    tick();
    bus.Z_in    = 1'b0;
    bus.Control = C_ADD;
    rd("mflo_zlow", 4'b1000, 32'h3);
    rd("mflo_hi", 4'b0001, 32'h2);

    // mfhi outside COMMIT reads HI register
    bus.Control = C_MFHI;
    bus.alu_C   = 64'h5555_5555_5555_5555;
    bus.Z_in    = 1'b1;
    tick();
    bus.Z_in    = 1'b0;
    rd("mfhi_idle", 4'b1000, 32'h2);

    // CON evaluation
    con_step("brzr_0", C_BRZR, 32'h0, 1'b1);
    con_step("brnz_0", C_BRNZ, 32'h0, 1'b0);
    con_step("brmi_neg", C_BRMI, 32'h8000_0000, 1'b1);
    con_step("brpl_neg", C_BRPL, 32'h8000_0000, 1'b0);
    con_step("brnz_1", C_BRNZ, 32'h0000_0100, 1'b1);
    con_step("add_0", C_ADD, 32'h0, 1'b0);
    con_step("brpl_pos", C_BRPL, 32'h7FFF_FFFF, 1'b1);
    bus.Control = C_BRNZ;
    bus.con_val = 32'h0;
    tick();
    check("con_hold", {63'b0, bus.CON}, 64'd1);

    // Z_in and con_in together
    bus.Control = C_BRZR;
    bus.con_val = 32'h1;
    bus.alu_C   = 64'h0000_0000_0000_1234;
    bus.Z_in    = 1'b1;
    bus.con_in  = 1'b1;
    tick();
    bus.Z_in    = 1'b0;
    bus.con_in  = 1'b0;
    check("both_con", {63'b0, bus.CON}, 64'd0);
    rd("both_z", 4'b1000, 32'h1234);

    // back-to-back div then mul, Clear during second COMMIT
    bus.Control = C_DIV;
    bus.alu_C   = 64'h0000_000A_0000_0014;
    bus.Z_in    = 1'b1;
    tick();
    bus.Control = C_MUL;
    bus.alu_C   = 64'h0000_0003_0000_0004;
    tick();
    bus.Z_in    = 1'b0;
    bus.Control = C_ADD;
    check("b2b_busy", {63'b0, bus.hilo_busy}, 64'd1);
    rd("b2b_hi", 4'b0001, 32'h0000_000A);
    rd("b2b_lo", 4'b0010, 32'h0000_0014);
    Clear = 1'b1;
    #1;
    check("clr_busy", {63'b0, bus.hilo_busy}, 64'd0);
    check("clr_zv", {63'b0, bus.z_valid}, 64'd0);
    check("clr_con", {63'b0, bus.CON}, 64'd0);
    rd("clr_hi", 4'b0001, 32'h0);
    rd("clr_lo", 4'b0010, 32'h0);
    rd("clr_zlow", 4'b1000, 32'h0);
    Clear = 1'b0;
    tick();
    tick();
    check("post_busy", {63'b0, bus.hilo_busy}, 64'd0);
    rd("post_hi", 4'b0001, 32'h0);
    rd("post_lo", 4'b0010, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
